// File: rtl/forward_scoreboard.sv
// rtl/forward_scoreboard.sv - ID-stage operand forwarding, load-use hazard detection and multi-cycle scoreboard
module forward_scoreboard #(
    parameter int NUM_READ   = 2,
    parameter int NUM_STAGES = 2,
    parameter int DATA_W     = 32,
    parameter int NREG       = 32,
    parameter int MAX_LAT    = 15,
    localparam int LAT_W     = $clog2(MAX_LAT + 1),
    localparam int AW        = $clog2(NREG)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_READ*AW-1:0]         raddr,
    input  logic [NUM_READ*DATA_W-1:0]     rf_rdata,
    input  logic [NUM_STAGES-1:0]          stg_we,
    input  logic [NUM_STAGES*AW-1:0]       stg_waddr,
    input  logic [NUM_STAGES*DATA_W-1:0]   stg_wdata,
    input  logic [NUM_STAGES-1:0]          stg_load,
    input  logic                           id_fire,
    input  logic                           mc_issue,
    input  logic [AW-1:0]                  mc_waddr,
    input  logic [LAT_W-1:0]               mc_lat,
    input  logic                           flush,
    output logic [NUM_READ*DATA_W-1:0]     fwd_rdata,
    output logic                           id_stall_req,
    output logic [NREG-1:0]                busy,
    output logic [31:0]                    stall_cycles
);

    logic [LAT_W-1:0]  cnt_q [1:NREG-1];
    logic [LAT_W-1:0]  cnt_d [1:NREG-1];
    logic [31:0]       stall_cycles_q;
    logic [31:0]       stall_cycles_d;
    logic              stall_req;
    logic              issue_ok;
    logic [AW-1:0]     ra;
    logic [DATA_W-1:0] val;
    logic              ld;

    // Stages are scanned oldest to youngest so the youngest match overwrites,
    // carrying its load flag along; an older load behind it is thereby masked.
    always_comb begin
        fwd_rdata = '0;
        stall_req = 1'b0;
        ra        = '0;
        val       = '0;
        ld        = 1'b0;
        for (int k = 0; k < NUM_READ; k++) begin
            ra  = raddr[k*AW +: AW];
            val = rf_rdata[k*DATA_W +: DATA_W];
            ld  = 1'b0;
            for (int s = NUM_STAGES - 1; s >= 0; s--) begin
                if (stg_we[s] && (stg_waddr[s*AW +: AW] == ra)) begin
                    val = stg_wdata[s*DATA_W +: DATA_W];
                    ld  = stg_load[s];
                end
            end
            if (ra == '0) begin
                val = '0;
                ld  = 1'b0;
            end
            fwd_rdata[k*DATA_W +: DATA_W] = val;
            stall_req = stall_req | ld | ((ra != '0) && busy[ra]);
        end
    end

    assign id_stall_req = stall_req;
    assign issue_ok     = id_fire && mc_issue && !stall_req && (mc_waddr != '0);

    always_comb begin
        for (int r = 1; r < NREG; r++) begin
            if (flush) begin
                cnt_d[r] = '0;
            end else if (issue_ok && (mc_waddr == AW'(r))) begin
                cnt_d[r] = mc_lat;
            end else if (cnt_q[r] != '0) begin
                cnt_d[r] = cnt_q[r] - LAT_W'(1);
            end else begin
                cnt_d[r] = cnt_q[r];
            end
        end
    end

    always_comb begin
        busy = '0;
        for (int r = 1; r < NREG; r++) begin
            busy[r] = (cnt_q[r] != '0);
        end
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall_req && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    assign stall_cycles = stall_cycles_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 1; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
            stall_cycles_q <= '0;
        end else begin
            for (int r = 1; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            stall_cycles_q <= stall_cycles_d;
        end
    end

endmodule

// File: tb/tb_forward_scoreboard.sv
// tb/tb_forward_scoreboard.sv - scoreboard bench for forward_scoreboard in default and 3-read/4-stage builds
module tb_forward_scoreboard;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic [9:0]  a_raddr = '0;
    logic [63:0] a_rf    = '0;
    logic [1:0]  a_we    = '0;
    logic [9:0]  a_waddr = '0;
    logic [63:0] a_wdata = '0;
    logic [1:0]  a_load  = '0;
    logic        a_fire  = 1'b0;
    logic        a_mci   = 1'b0;
    logic [4:0]  a_mcw   = '0;
    logic [3:0]  a_lat   = '0;
    logic        a_flush = 1'b0;
    logic [63:0] a_fwd;
    logic        a_stall;
    logic [31:0] a_busy;
    logic [31:0] a_sc;

    logic [14:0]  b_raddr = '0;
    logic [95:0]  b_rf    = '0;
    logic [3:0]   b_we    = '0;
    logic [19:0]  b_waddr = '0;
    logic [127:0] b_wdata = '0;
    logic [3:0]   b_load  = '0;
    logic [95:0]  b_fwd;
    logic         b_stall;
    logic [31:0]  b_busy;
    logic [31:0]  b_sc;

    string       name_q[$];
    int          sel_q[$];
    logic [63:0] exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    forward_scoreboard dut_a (
        .clk(clk), .rst_n(rst_n), .raddr(a_raddr), .rf_rdata(a_rf),
        .stg_we(a_we), .stg_waddr(a_waddr), .stg_wdata(a_wdata), .stg_load(a_load),
        .id_fire(a_fire), .mc_issue(a_mci), .mc_waddr(a_mcw), .mc_lat(a_lat), .flush(a_flush),
        .fwd_rdata(a_fwd), .id_stall_req(a_stall), .busy(a_busy), .stall_cycles(a_sc)
    );

    forward_scoreboard #(.NUM_READ(3), .NUM_STAGES(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .raddr(b_raddr), .rf_rdata(b_rf),
        .stg_we(b_we), .stg_waddr(b_waddr), .stg_wdata(b_wdata), .stg_load(b_load),
        .id_fire(1'b0), .mc_issue(1'b0), .mc_waddr(5'd0), .mc_lat(4'd0), .flush(1'b0),
        .fwd_rdata(b_fwd), .id_stall_req(b_stall), .busy(b_busy), .stall_cycles(b_sc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input int sel, input logic [63:0] e);
        name_q.push_back(n);
        sel_q.push_back(sel);
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] r, input logic [3:0] l);
        a_fire = 1'b1;
        a_mci  = 1'b1;
        a_mcw  = r;
        a_lat  = l;
    endtask

    task automatic idle();
        a_fire = 1'b0;
        a_mci  = 1'b0;
    endtask

    initial begin
        string       n;
        int          sel;
        logic [63:0] e;
        logic [63:0] act;
        forever begin
            @(negedge clk or negedge rst_n);
            #1;
            while (sel_q.size() > 0) begin
                n   = name_q.pop_front();
                sel = sel_q.pop_front();
                e   = exp_q.pop_front();
                case (sel)
                    0:       act = {32'b0, a_fwd[31:0]};
                    1:       act = {32'b0, a_fwd[63:32]};
                    2:       act = {63'b0, a_stall};
                    3:       act = {32'b0, a_busy};
                    4:       act = {32'b0, a_sc};
                    5:       act = {32'b0, b_fwd[31:0]};
                    6:       act = {32'b0, b_fwd[63:32]};
                    7:       act = {32'b0, b_fwd[95:64]};
                    8:       act = {63'b0, b_stall};
                    9:       act = {32'b0, b_sc};
                    default: act = 'x;
                endcase
                n_checks++;
                if (act !== e) begin
                    $display("FAIL %s: got %0h expected %0h", n, act, e);
                end else begin
                    n_pass++;
                end
            end
        end
    end

    initial begin
        chk("rst_busy", 3, 0);
        chk("rst_sc", 4, 0);
        chk("rst_stall", 2, 0);
        chk("rst_fwd0", 0, 0);
        chk("rst_b_stall", 8, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        tick();

        a_rf = {32'hF1F1_0001, 32'hF0F0_0000};
        a_raddr[4:0] = 5'd5;
        chk("rf_fallthrough", 0, 32'hF0F0_0000);
        tick();
        a_we = 2'b11;
        a_waddr = {5'd5, 5'd5};
        a_wdata = {32'h0000_BBBB, 32'h0000_AAAA};
        chk("prio_stage0", 0, 32'h0000_AAAA);
        chk("prio_no_stall", 2, 0);
        tick();
        a_we = 2'b10;
        chk("prio_stage1", 0, 32'h0000_BBBB);
        tick();
        a_raddr[4:0] = 5'd0;
        a_we = 2'b01;
        a_waddr[4:0] = 5'd0;
        a_wdata[31:0] = 32'h0000_1234;
        chk("r0_zero", 0, 0);
        tick();

        a_we = 2'b01;
        a_waddr = {5'd0, 5'd3};
        a_load = 2'b01;
        a_wdata[31:0] = 32'h0000_3030;
        a_raddr = {5'd3, 5'd0};
        chk("load_stall", 2, 1);
        chk("load_fwd_value", 1, 32'h0000_3030);
        tick();
        a_we = 2'b11;
        a_waddr = {5'd3, 5'd3};
        a_load = 2'b10;
        a_wdata = {32'h0000_DEAD, 32'h0000_3333};
        chk("mask_no_stall", 2, 0);
        chk("mask_fwd", 1, 32'h0000_3333);
        chk("sc_after_load", 4, 1);
        tick();

        a_we = '0;
        a_load = '0;
        a_raddr = '0;
        issue(5'd7, 4'd4);
        chk("mc_pre_busy", 3, 0);
        tick();
        idle();
        a_raddr[4:0] = 5'd7;
        for (int i = 0; i < 4; i++) begin
            chk("mc_busy7", 3, 32'h80);
            chk("mc_stall", 2, 1);
            tick();
        end
        chk("mc_busy_done", 3, 0);
        chk("mc_stall_done", 2, 0);
        chk("mc_sc", 4, 5);

        a_raddr = '0;
        issue(5'd7, 4'd4);
        tick();
        idle();
        chk("waw_t1", 3, 32'h80);
        tick();
        chk("waw_t2", 3, 32'h80);
        issue(5'd7, 4'd3);
        tick();
        a_raddr[4:0] = 5'd7;
        issue(5'd9, 4'd5);
        chk("stalled_issue_stall", 2, 1);
        chk("waw_t3", 3, 32'h80);
        tick();
        idle();
        a_raddr = '0;
        chk("stalled_issue_ignored", 3, 32'h80);
        tick();
        chk("waw_t5", 3, 32'h80);
        tick();
        chk("waw_done", 3, 0);
        chk("waw_sc", 4, 6);

        issue(5'd2, 4'd5);
        tick();
        issue(5'd9, 4'd5);
        tick();
        idle();
        chk("pre_flush_busy", 3, 32'h204);
        a_flush = 1'b1;
        issue(5'd4, 4'd5);
        tick();
        a_flush = 1'b0;
        idle();
        chk("flush_busy", 3, 0);
        chk("flush_keeps_sc", 4, 6);
        tick();

        issue(5'd7, 4'd6);
        tick();
        idle();
        a_raddr[4:0] = 5'd7;
        for (int i = 0; i < 4; i++) tick();
        chk("pre_rst_sc", 4, 10);
        chk("pre_rst_busy", 3, 32'h80);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        chk("async_rst_busy", 3, 0);
        chk("async_rst_sc", 4, 0);
        chk("async_rst_stall", 2, 0);
        tick();
        a_raddr = '0;
        rst_n = 1'b1;
        tick();
        chk("post_rst_busy", 3, 0);
        chk("post_rst_sc", 4, 0);
        tick();

        b_rf = {32'h0000_00C2, 32'h0000_00C1, 32'h0000_00C0};
        b_we = 4'b1100;
        b_waddr[10 +: 5] = 5'd5;
        b_waddr[15 +: 5] = 5'd5;
        b_wdata[64 +: 32] = 32'h0000_AAAA;
        b_wdata[96 +: 32] = 32'h0000_BBBB;
        b_raddr[10 +: 5] = 5'd5;
        chk("b_prio_s2", 7, 32'h0000_AAAA);
        chk("b_no_stall", 8, 0);
        chk("b_rf_port0", 5, 0);
        tick();
        b_we = 4'b1110;
        b_waddr[5 +: 5] = 5'd5;
        b_wdata[32 +: 32] = 32'h0000_1111;
        chk("b_prio_s1", 7, 32'h0000_1111);
        tick();
        b_we = 4'b1000;
        chk("b_prio_s3", 7, 32'h0000_BBBB);
        tick();
        b_raddr = '0;
        b_we = 4'b0001;
        b_waddr[0 +: 5] = 5'd0;
        b_wdata[0 +: 32] = 32'h0000_9999;
        chk("b_r0_port1", 6, 0);
        chk("b_r0_port2", 7, 0);
        tick();
        b_we = 4'b1000;
        b_waddr[15 +: 5] = 5'd3;
        b_wdata[96 +: 32] = 32'h0000_3333;
        b_load = 4'b1000;
        b_raddr[0 +: 5] = 5'd3;
        chk("b_load_stall", 8, 1);
        tick();
        b_we = 4'b1010;
        b_waddr[5 +: 5] = 5'd3;
        b_wdata[32 +: 32] = 32'h0000_4444;
        chk("b_mask_no_stall", 8, 0);
        chk("b_mask_fwd", 5, 32'h0000_4444);
        chk("b_sc", 9, 1);
        tick();
        tick();

        if (sel_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: got %0d pending expected 0", sel_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
